// File: rtl/uart_tx_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// Module   : uart_tx_pkg
// Purpose  : Shared types and constants for the UART transmit controller.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package uart_tx_pkg;

  // Frame sequencing states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Select codes for the downstream 4:1 TX output mux
  localparam logic [1:0] SEL_START = 2'b00;
  localparam logic [1:0] SEL_STOP  = 2'b01;
  localparam logic [1:0] SEL_DATA  = 2'b10;
  localparam logic [1:0] SEL_PAR   = 2'b11;

  // Parity type encoding on PAR_TYP
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage : uart_tx_pkg
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// Module   : uart_tx_serializer
// Purpose  : Load/shift register presenting the payload LSB first, plus the
//            bit counter that flags the final data bit.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  shift_en,
  output logic                  ser_data,
  output logic                  ser_done
);
  import uart_tx_pkg::*;

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_count;

  assign ser_data = r_shift[0];
  // Final data bit is being presented while the counter sits on its last value
  assign ser_done = shift_en && (r_count == C_LAST_BIT);

  // Load on acceptance, shift right once per data bit; counter wraps to 0 on
  // the last bit so it is ready for the next frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (load) begin
      r_shift <= load_data;
      r_count <= '0;
    end else if (shift_en) begin
      r_shift <= r_shift >> 1;
      r_count <= ser_done ? '0 : r_count + 1'b1;
    end
  end

endmodule : uart_tx_serializer
`default_nettype wire

// File: rtl/uart_tx_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// Module   : uart_tx_controller
// Purpose  : Sequences a UART frame (start, data LSB first, optional parity,
//            stop) by driving the select/data/parity inputs of the TX mux.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module uart_tx_controller #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);
  import uart_tx_pkg::*;

  tx_state_e r_state;
  tx_state_e w_next_state;
  logic      r_par_en;
  logic      r_par_bit;
  logic      r_busy;
  logic      w_accept;
  logic      w_shift_en;
  logic      w_ser_done;

  // A new frame can only be taken when idle or in the final (stop) cycle,
  // which gives back-to-back frames without an idle gap
  assign w_accept   = Data_Valid && ((r_state == IDLE) || (r_state == STOP));
  assign w_shift_en = (r_state == DATA);

  assign par_bit = r_par_bit;
  assign busy    = r_busy;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_serializer (
    .clk       (CLK),
    .rst       (RST),
    .load      (w_accept),
    .load_data (P_DATA),
    .shift_en  (w_shift_en),
    .ser_data  (ser_data),
    .ser_done  (w_ser_done)
  );

  // Next-state selection and mux select decode from the current state
  always_comb begin
    w_next_state = r_state;
    mux_sel      = SEL_STOP;
    case (r_state)
      IDLE: begin
        mux_sel = SEL_STOP;
        if (w_accept) w_next_state = START;
      end
      START: begin
        mux_sel      = SEL_START;
        w_next_state = DATA;
      end
      DATA: begin
        mux_sel = SEL_DATA;
        if (w_ser_done) w_next_state = r_par_en ? PARITY : STOP;
      end
      PARITY: begin
        mux_sel      = SEL_PAR;
        w_next_state = STOP;
      end
      STOP: begin
        mux_sel      = SEL_STOP;
        w_next_state = w_accept ? START : IDLE;
      end
      default: begin
        mux_sel      = SEL_STOP;
        w_next_state = IDLE;
      end
    endcase
  end

  // State, busy flag and per-frame settings; parity is computed once from the
  // payload at acceptance and held until the next acceptance
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != IDLE);
      if (w_accept) begin
        r_par_en  <= PAR_EN;
        r_par_bit <= (PAR_TYP == PAR_ODD) ? ~^P_DATA : ^P_DATA;
      end
    end
  end

endmodule : uart_tx_controller
`default_nettype wire
